// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: shared definitions for the MIPS execute stage.
//   - aluop / alusel encodings produced by decode and consumed by ex_unit
//   - reset / write-enable polarities, zero word, NOP register address
//   - bus widths and the iterative-multiplier state type
package ex_unit_pkg;

  // Bus widths
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Polarities and constants
  localparam logic                  RstEnable    = 1'b0;
  localparam logic                  RstDisable   = 1'b1;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic [REG_DATA_W-1:0] ZeroWord     = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOPRegAddr   = 5'b00000;

  // aluop codes
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;

  // alusel result classes
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

endpackage

// File: rtl/ex_unit_mul_iter.sv
// ex_unit_mul_iter: iterative shift-add multiplier (the mul_iter block of ex_unit).
//   clk, rst        clock, asynchronous active-low reset
//   start_i         a MULT/MULTU sits in EX
//   signed_i        1 = MULT (signed), 0 = MULTU
//   a_i, b_i        operands
//   flush_i         abandon the multiply, return to IDLE
//   stall_i         downstream stall; holds the finished product in DONE
//   done_o          product_o is valid (DONE state)
//   stall_req_o     freeze request: start cycle plus every BUSY cycle
//   product_o       signed/unsigned 2*DATA_W-bit product
module ex_unit_mul_iter
  import ex_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  done_o,
  output logic                  stall_req_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  mul_state_e                state_q,  state_d;
  logic                      busy_q,   busy_d;
  logic                      done_q,   done_d;
  logic                      neg_q,    neg_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;
  logic [2*DATA_W-1:0]       mcand_q,  mcand_d;
  logic [2*DATA_W-1:0]       acc_q,    acc_d;
  logic [DATA_W-1:0]         mplier_q, mplier_d;
  logic                      start_ok;

  // Magnitude of a two's complement value; the most negative value maps to
  // its correct unsigned magnitude because the result is read as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return v[DATA_W-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  assign start_ok    = (state_q == MUL_IDLE) && start_i && !flush_i;
  // The start cycle itself must already freeze the pipeline.
  assign stall_req_o = start_ok || busy_q;
  assign done_o      = done_q;
  assign product_o   = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_ok) begin
          state_d  = MUL_BUSY;
          busy_d   = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
          neg_d    = signed_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
          mcand_d  = {{DATA_W{1'b0}}, (signed_i ? mag(a_i) : a_i)};
          mplier_d = signed_i ? mag(b_i) : b_i;
        end
      end
      MUL_BUSY: begin
        if (flush_i) begin
          state_d = MUL_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
            state_d = MUL_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      MUL_DONE: begin
        // Leaving DONE without flush is the edge on which HI/LO take the product.
        if (flush_i || !stall_i) begin
          state_d = MUL_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q  <= MUL_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/ex_unit.sv
// ex_unit: execute stage of the 5-stage MIPS pipeline.
//   Inputs : clk, rst (async, active-low), decoded bundle aluop_i/alusel_i/
//            reg1_i/reg2_i/wd_i/wreg_i, stall_i (hold EX/MEM), flush_i (kill EX)
//   Outputs: ex_wreg_o/ex_wd_o/ex_wdata_o   zero-latency EX->ID forwarding
//            mem_wreg_o/mem_wd_o/mem_wdata_o registered EX/MEM bundle
//            hi_o/lo_o                      HI/LO registers
//            stall_req_o                    multiply in flight
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_wreg_o,
  output logic [REG_ADDR_W-1:0] ex_wd_o,
  output logic [DATA_W-1:0]     ex_wdata_o,
  output logic                  mem_wreg_o,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stall_req_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]        ex_result;
  logic [SH_W-1:0]          shamt;
  logic signed [DATA_W-1:0] reg2_s;
  logic                     is_mul;
  logic                     mul_done;
  logic                     mul_stall_req;
  logic [2*DATA_W-1:0]      mul_product;

  logic                  mem_wreg_q,  mem_wreg_d;
  logic [REG_ADDR_W-1:0] mem_wd_q,    mem_wd_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     hi_q,        hi_d;
  logic [DATA_W-1:0]     lo_q,        lo_d;

  assign shamt  = reg1_i[SH_W-1:0];
  assign reg2_s = reg2_i;
  assign is_mul = is_mul_op(aluop_i);

  // ---- EX: combinational result ----
  always_comb begin
    ex_result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  ex_result = reg1_i | reg2_i;
          EXE_AND_OP: ex_result = reg1_i & reg2_i;
          EXE_XOR_OP: ex_result = reg1_i ^ reg2_i;
          EXE_NOR_OP: ex_result = ~(reg1_i | reg2_i);
          default:    ex_result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: ex_result = reg2_i << shamt;
          EXE_SRL_OP: ex_result = reg2_i >> shamt;
          EXE_SRA_OP: ex_result = reg2_s >>> shamt;
          default:    ex_result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: ex_result = hi_q;
          EXE_MFLO_OP: ex_result = lo_q;
          EXE_MOVN_OP,
          EXE_MOVZ_OP: ex_result = reg1_i;
          default:     ex_result = '0;
        endcase
      end
      default: ex_result = '0;
    endcase
  end

  // Forwarding bus is forced quiet while reset is held.
  assign ex_wreg_o   = (rst == RstEnable) ? 1'b0 : wreg_i;
  assign ex_wd_o     = (rst == RstEnable) ? NOPRegAddr : wd_i;
  assign ex_wdata_o  = (rst == RstEnable) ? '0 : ex_result;
  assign stall_req_o = (rst == RstEnable) ? 1'b0 : mul_stall_req;

  ex_unit_mul_iter #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_iter (
    .clk         (clk),
    .rst         (rst),
    .start_i     (is_mul),
    .signed_i    (aluop_i == EXE_MULT_OP),
    .a_i         (reg1_i),
    .b_i         (reg2_i),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .done_o      (mul_done),
    .stall_req_o (mul_stall_req),
    .product_o   (mul_product)
  );

  always_comb begin
    mem_wreg_d  = mem_wreg_q;
    mem_wd_d    = mem_wd_q;
    mem_wdata_d = mem_wdata_q;
    if (!stall_i) begin
      if (flush_i) begin
        mem_wreg_d  = WriteDisable;
        mem_wd_d    = NOPRegAddr;
        mem_wdata_d = '0;
      end else begin
        // Multiplies only target HI/LO, never a GPR.
        mem_wreg_d  = wreg_i && !is_mul;
        mem_wd_d    = wd_i;
        mem_wdata_d = ex_result;
      end
    end
  end

  // HI/LO change only when the instruction actually leaves EX. A multiply
  // completion and MTHI/MTLO never coincide since the pipeline is frozen
  // while the multiplier is busy.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall_i && !flush_i) begin
      if (mul_done) begin
        hi_d = mul_product[2*DATA_W-1:DATA_W];
        lo_d = mul_product[DATA_W-1:0];
      end else if (aluop_i == EXE_MTHI_OP) begin
        hi_d = reg1_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        lo_d = reg1_i;
      end
    end
  end

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      mem_wreg_q  <= WriteDisable;
      mem_wd_q    <= NOPRegAddr;
      mem_wdata_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      mem_wreg_q  <= mem_wreg_d;
      mem_wd_q    <= mem_wd_d;
      mem_wdata_q <= mem_wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_wreg_o  = mem_wreg_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_wdata_o = mem_wdata_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule
